// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file write path.
//   XLEN / REG_AW / NUM_REGS : datapath and register-index sizing
//   reg_idx_t                : architectural register index
//   rf_wr_t                  : one register-file write (enable, address, data),
//                              same shape as the pipeline writeback stage uses
package rf_ctrl_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef struct packed {
    logic            we;
    reg_idx_t        rd;
    logic [XLEN-1:0] wdata;
  } rf_wr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard for outstanding mul/div destinations.
//   clk, rst              : clock, async active-high reset
//   set_en / set_idx      : mul/div issue (marks destination busy, counts up)
//   clr_en / clr_idx      : buffered result commit (clears busy, counts down)
//   query_valid/query_md  : decode holds an instruction / it targets mul/div
//   rs1, rs2, rd          : decode indices checked against the busy vector
//   stall                 : decode hazard (RAW/WAW or issue limit reached)
//   pending               : outstanding mul/div count
module reg_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  reg_idx_t          set_idx,
  input  logic              clr_en,
  input  reg_idx_t          clr_idx,
  input  logic              query_valid,
  input  logic              query_md,
  input  reg_idx_t          rs1,
  input  reg_idx_t          rs2,
  input  reg_idx_t          rd,
  output logic              stall,
  output logic [REG_AW-1:0] pending
);
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic                dec_ok;

  // Clear first so a same-index set in the same cycle wins; x0 never busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // A commit with nothing outstanding is a stray result; ignore its decrement.
  assign dec_ok = clr_en & (pending != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pending <= '0;
    else if (set_en && !dec_ok) pending <= pending + REG_AW'(1);
    else if (!set_en && dec_ok) pending <= pending - REG_AW'(1);
  end

  assign stall = query_valid & (busy[rs1] | busy[rs2] | busy[rd] |
                 (query_md & (pending == REG_AW'(MAX_PENDING))));
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbiter for the single register-file write port, shared by pipeline
// writeback (priority) and the mul/div unit (through a one-entry skid buffer).
//   clk, rst                       : clock, async active-high reset
//   dec_*                          : decode instruction; dec_stall holds it
//   wb_valid/wb_rd/wb_data         : pipeline writeback request
//   wb_hold                        : pipeline must bubble next cycle
//   md_valid/md_rd/md_data/md_ready: mul/div result handshake
//   rf_we/rf_rd/rf_wdata           : register-file write port
//   md_pending                     : outstanding mul/div count
module regfile_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_PENDING  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        dec_is_md,
  output logic        dec_stall,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        wb_hold,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic [4:0]  md_pending
);
  localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT - 1);

  logic            buf_valid;
  reg_idx_t        buf_rd;
  logic [XLEN-1:0] buf_data;
  logic [CW-1:0]   wait_cnt;
  logic            drain, ready_int, load, issue, stall_int, hold_int;
  rf_wr_t          wr;

  // The buffer only gets the port when the pipeline leaves it idle.
  assign drain     = buf_valid & ~wb_valid;
  assign ready_int = ~buf_valid | drain;
  assign load      = md_valid & ready_int;
  assign issue     = dec_valid & dec_is_md & ~stall_int;

  reg_scoreboard #(.MAX_PENDING(MAX_PENDING)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en     (issue),
    .set_idx    (dec_rd),
    .clr_en     (drain),
    .clr_idx    (buf_rd),
    .query_valid(dec_valid),
    .query_md   (dec_is_md),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .rd         (dec_rd),
    .stall      (stall_int),
    .pending    (md_pending)
  );

  always_comb begin
    wr = '0;
    if (wb_valid) begin
      wr.we    = (wb_rd != '0);
      wr.rd    = wb_rd;
      wr.wdata = wb_data;
    end else if (buf_valid) begin
      wr.we    = (buf_rd != '0);
      wr.rd    = buf_rd;
      wr.wdata = buf_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_rd    <= '0;
      buf_data  <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_rd    <= md_rd;
      buf_data  <= md_data;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  // Saturating at the limit keeps wb_hold up if the pipeline ignores it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 wait_cnt <= '0;
    else if (!buf_valid || drain)            wait_cnt <= '0;
    else if (wb_valid && wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CW'(1);
  end

  assign hold_int = buf_valid & wb_valid & (wait_cnt == CNT_MAX);

  assign dec_stall = ~rst & stall_int;
  assign wb_hold   = ~rst & hold_int;
  assign md_ready  = ~rst & ready_int;
  assign rf_we     = ~rst & wr.we;
  assign rf_rd     = rst ? '0 : wr.rd;
  assign rf_wdata  = rst ? '0 : wr.wdata;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int SL = 4;
  localparam int MP = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        dec_valid = 0, dec_is_md = 0, wb_valid = 0, md_valid = 0;
  logic [4:0]  dec_rs1 = 0, dec_rs2 = 0, dec_rd = 0, wb_rd = 0, md_rd = 0;
  logic [31:0] wb_data = 0, md_data = 0;
  logic        dec_stall, wb_hold, md_ready, rf_we;
  logic [4:0]  rf_rd, md_pending;
  logic [31:0] rf_wdata;

  int n_cmp = 0, n_err = 0;

  regfile_write_arbiter #(.STARVE_LIMIT(SL), .MAX_PENDING(MP)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_is_md(dec_is_md), .dec_stall(dec_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_hold(wb_hold),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .md_pending(md_pending)
  );

  always #5 clk = ~clk;

  // Reference state: busy set, outstanding count, buffered result and
  // how many cycles it has been blocked by pipeline writeback.
  bit          m_busy[32];
  int          m_pend;
  bit          m_bv;
  int          m_brd;
  logic [31:0] m_bdata;
  int          m_blk;

  logic        e_issue, e_ready, e_hold;
  logic        s_stall, s_hold, s_ready, s_we;
  logic [4:0]  s_rd, s_pend;
  logic [31:0] s_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_pend = 0; m_bv = 0; m_brd = 0; m_bdata = 0; m_blk = 0;
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_is_md = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; md_valid = 0; md_rd = 0; md_data = 0;
  endtask

  // One clock cycle: drive, check every output against the model, advance.
  task automatic cyc(input logic dv, input int r1, input int r2, input int rd, input logic md,
                     input logic wv, input int wr, input logic [31:0] wd,
                     input logic mv, input int mr, input logic [31:0] mdd);
    logic es, dr, er, eh, ewe;
    int erd;
    logic [31:0] ed;
    @(negedge clk);
    dec_valid = dv; dec_rs1 = 5'(r1); dec_rs2 = 5'(r2); dec_rd = 5'(rd); dec_is_md = md;
    wb_valid = wv; wb_rd = 5'(wr); wb_data = wd;
    md_valid = mv; md_rd = 5'(mr); md_data = mdd;
    #1;
    es = dv & (m_busy[r1] | m_busy[r2] | m_busy[rd] | (md && m_pend == MP));
    dr = m_bv & !wv;
    er = !m_bv | dr;
    eh = m_bv & wv & (m_blk >= SL - 1);
    if (wv)        begin ewe = (wr != 0);    erd = wr;    ed = wd;      end
    else if (m_bv) begin ewe = (m_brd != 0); erd = m_brd; ed = m_bdata; end
    else           begin ewe = 0;            erd = 0;     ed = 0;       end
    s_stall = dec_stall; s_hold = wb_hold; s_ready = md_ready; s_we = rf_we;
    s_rd = rf_rd; s_data = rf_wdata; s_pend = md_pending;
    chk("dec_stall", s_stall, es);
    chk("wb_hold", s_hold, eh);
    chk("md_ready", s_ready, er);
    chk("rf_we", s_we, ewe);
    chk("rf_rd", s_rd, erd);
    chk("rf_wdata", s_data, ed);
    chk("md_pending", s_pend, m_pend);
    e_issue = dv & md & !es; e_ready = er; e_hold = eh;
    @(posedge clk);
    if (dr) m_busy[m_brd] = 0;
    if (e_issue && rd != 0) m_busy[rd] = 1;
    m_pend = m_pend + (e_issue ? 1 : 0) - ((dr && m_pend > 0) ? 1 : 0);
    if (m_bv && wv) m_blk++; else m_blk = 0;
    if (mv && er) begin m_bv = 1; m_brd = mr; m_bdata = mdd; end
    else if (dr) m_bv = 0;
  endtask

  // Reset asserted between edges; outputs must drop at once.
  task automatic do_reset();
    @(negedge clk);
    dec_valid = 1; dec_rs1 = 5; dec_is_md = 1; wb_valid = 1; wb_rd = 3; md_valid = 1;
    rst = 1;
    #1;
    chk("rst_dec_stall", dec_stall, 0);
    chk("rst_wb_hold", wb_hold, 0);
    chk("rst_md_ready", md_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_md_pending", md_pending, 0);
    idle_inputs();
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  initial begin
    int q[$];
    logic last_hold, dv, md, wv, mv, from_q;
    int r1, r2, rd, wr, mr;
    model_clear();
    do_reset();

    // Reset mid-operation: busy[5] set and a result parked in the buffer.
    cyc(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'h55, 1, 6, 32'h66);
    do_reset();
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_ready", s_ready, 1);
    chk("post_rst_pend", s_pend, 0);
    chk("post_rst_stall", s_stall, 0);

    // RAW release timing on r7.
    cyc(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("raw_stall_on", s_stall, 1);
    cyc(1, 7, 0, 0, 0, 0, 0, 0, 1, 7, 32'h2A);
    chk("raw_stall_accept", s_stall, 1);
    cyc(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("raw_commit_we", s_we, 1);
    chk("raw_commit_rd", s_rd, 7);
    chk("raw_commit_data", s_data, 32'h2A);
    chk("raw_stall_commit", s_stall, 1);
    cyc(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("raw_stall_off", s_stall, 0);

    // Same-cycle collision: pipeline first, buffered result next.
    cyc(0, 0, 0, 0, 0, 1, 3, 32'h11, 1, 9, 32'h22);
    chk("coll_rd1", s_rd, 3);
    chk("coll_data1", s_data, 32'h11);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("coll_rd2", s_rd, 9);
    chk("coll_data2", s_data, 32'h22);

    // Starvation under continuous writeback.
    cyc(0, 0, 0, 0, 0, 1, 1, 32'hA, 1, 12, 32'hC);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0, 0, 1, 2, 32'hB, 0, 0, 0);
      chk("starve_hold", s_hold, (k == 4));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("starve_rd", s_rd, 12);
    chk("starve_ready", s_ready, 1);

    // Hold ignored by the pipeline: pipeline still wins, hold stays up.
    cyc(0, 0, 0, 0, 0, 1, 1, 32'hA, 1, 13, 32'hD);
    for (int k = 1; k <= 4; k++) cyc(0, 0, 0, 0, 0, 1, 2, 32'hB, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 4, 32'hE, 0, 0, 0);
    chk("viol_hold", s_hold, 1);
    chk("viol_rd", s_rd, 4);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("viol_drain_rd", s_rd, 13);

    // Issue limit.
    for (int k = 1; k <= 4; k++) cyc(1, 0, 0, k, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 5, 1, 0, 0, 0, 1, 1, 32'h100);
    chk("lim_stall", s_stall, 1);
    chk("lim_pend", s_pend, 4);
    cyc(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("lim_release", s_stall, 0);
    do_reset();

    // x0 destination for mul/div.
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h77);
    chk("x0_stall", s_stall, 0);
    chk("x0_pend", s_pend, 1);
    chk("x0_ready", s_ready, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_we", s_we, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_pend_done", s_pend, 0);

    // Randomized traffic against the model.
    do_reset();
    last_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin do_reset(); q.delete(); last_hold = 0; end
      dv = ($urandom % 4) != 0;
      r1 = $urandom % 8; r2 = $urandom % 8; rd = $urandom % 8;
      md = ($urandom % 3) == 0;
      wv = last_hold ? 1'b0 : (($urandom % 4) != 0);
      wr = $urandom % 32;
      mv = 0; mr = 0; from_q = 0;
      if (q.size() > 0 && ($urandom % 2) == 1) begin mv = 1; mr = q[0]; from_q = 1; end
      else if (($urandom % 16) == 0) begin mv = 1; mr = $urandom % 32; end
      cyc(dv, r1, r2, rd, md, wv, wr, $urandom, mv, mr, $urandom);
      if (e_issue) q.push_back(rd);
      if (from_q && e_ready) void'(q.pop_front());
      last_hold = e_hold;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
